// File: rtl/spio_link_speed_doubler.sv
// Synchronous 1x -> 2x clock-rate packet stream bridge built on a circular buffer.
// Optional SPIO_LSD_OUTPUT_REG_EN adds a registered fclk_i output stage with a 2-entry skid buffer.
module spio_link_speed_doubler #(
    parameter int PKT_BITS  = 16,
    parameter int ADDR_BITS = 2
) (
    input  logic                sclk_i,
    input  logic                reset_i,
    input  logic                fclk_i,
    input  logic [PKT_BITS-1:0] in_data_i,
    input  logic                in_vld_i,
    output logic                in_rdy_o,
    output logic [PKT_BITS-1:0] out_data_o,
    output logic                out_vld_o,
    input  logic                out_rdy_i
);
    localparam int                 DEPTH    = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] FULL_OCC = (ADDR_BITS + 1)'(DEPTH);

    logic [PKT_BITS-1:0] mem [DEPTH];
    logic [ADDR_BITS:0]  wptr, rptr, occ;
    logic                full, empty, wr_en, rd_en;
    logic [PKT_BITS-1:0] head;

    // Clocks are edge-aligned, so pointers cross domains directly; a read on the
    // coincident edge only frees space after that edge.
    assign occ      = wptr - rptr;
    assign full     = (occ == FULL_OCC);
    assign empty    = (occ == '0);
    assign in_rdy_o = reset_i & ~full;
    assign wr_en    = in_vld_i & in_rdy_o;
    assign head     = mem[rptr[ADDR_BITS-1:0]];

    always_ff @(posedge sclk_i or negedge reset_i) begin
        if (!reset_i)   wptr <= '0;
        else if (wr_en) wptr <= wptr + 1'b1;
    end

    always_ff @(posedge sclk_i) begin
        if (wr_en) mem[wptr[ADDR_BITS-1:0]] <= in_data_i;
    end

    always_ff @(posedge fclk_i or negedge reset_i) begin
        if (!reset_i)   rptr <= '0;
        else if (rd_en) rptr <= rptr + 1'b1;
    end

`ifdef SPIO_LSD_OUTPUT_REG_EN
    logic [PKT_BITS-1:0] q_data, skid_data;
    logic                q_vld, skid_vld;

    // Popping depends only on registered state, keeping out_rdy_i off combinational paths.
    assign rd_en = ~empty & ~skid_vld;

    always_ff @(posedge fclk_i or negedge reset_i) begin
        if (!reset_i) begin
            q_data    <= '0;
            q_vld     <= 1'b0;
            skid_data <= '0;
            skid_vld  <= 1'b0;
        end else if (!q_vld || out_rdy_i) begin
            if (skid_vld) begin
                q_data   <= skid_data;
                q_vld    <= 1'b1;
                skid_vld <= 1'b0;
            end else begin
                q_vld  <= rd_en;
                q_data <= rd_en ? head : '0;
            end
        end else if (rd_en) begin
            skid_data <= head;
            skid_vld  <= 1'b1;
        end
    end

    assign out_data_o = q_data;
    assign out_vld_o  = q_vld;
`else
    assign rd_en      = ~empty & out_rdy_i;
    assign out_vld_o  = ~empty;
    assign out_data_o = empty ? '0 : head;
`endif

endmodule

// File: tb/tb_spio_link_speed_doubler.sv
// Directed bench for spio_link_speed_doubler: sequence scoreboard on the fast side,
// occupancy and handshake checks at chosen points of each scenario.
module tb_spio_link_speed_doubler;
    logic        sclk, fclk, reset_n;
    logic [15:0] in_data, out_data;
    logic        in_vld, in_rdy, out_vld, out_rdy;

    int checks = 0;
    int errors = 0;
    int src    = 0;   // packets accepted by the DUT
    int exp    = 0;   // packets delivered (next expected value)
    int n_out  = 0;
    logic        hold_pend = 1'b0;
    logic [15:0] hold_val  = '0;

    spio_link_speed_doubler #(.PKT_BITS(16), .ADDR_BITS(2)) dut (
        .sclk_i(sclk), .reset_i(reset_n), .fclk_i(fclk),
        .in_data_i(in_data), .in_vld_i(in_vld), .in_rdy_o(in_rdy),
        .out_data_o(out_data), .out_vld_o(out_vld), .out_rdy_i(out_rdy)
    );

    // Aligned rising edges: sclk rises on every other fclk rising edge.
    initial begin
        sclk = 0; fclk = 0;
        forever begin
            #5 sclk = 1; fclk = 1;
            #5 fclk = 0;
            #5 sclk = 0; fclk = 1;
            #5 fclk = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d t=%0t", tag, got, want, $time);
        end
    endtask

    // Source: handshake decided at the negedge preceding each sclk rise.
    initial begin
        logic take;
        in_data = '0;
        forever begin
            @(negedge fclk);
            take = reset_n && !sclk && in_vld && in_rdy;
            if (!reset_n) src = 0;
            @(posedge fclk);
            #1;
            if (take) src++;
            in_data = 16'(src);
        end
    end

    // Sink scoreboard: values seen at the negedge are what the next fclk edge samples.
    initial begin
        forever begin
            @(negedge fclk);
            if (!reset_n) begin
                exp = 0;
                hold_pend = 1'b0;
            end else begin
                if (hold_pend && out_vld) chk("hold", 32'(out_data), 32'(hold_val));
                if (out_vld && out_rdy) begin
                    chk("seq", 32'(out_data), 32'(16'(exp)));
                    exp++;
                    n_out++;
                end
                hold_pend = out_vld && !out_rdy;
                hold_val  = out_data;
            end
        end
    end

    task automatic sclk_cycles(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    initial begin
        int n0, e0;
        reset_n = 0; in_vld = 0; out_rdy = 0;
        #50;
        chk("rst_in_rdy", 32'(in_rdy), 0);
        chk("rst_out_vld", 32'(out_vld), 0);
        chk("rst_out_data", 32'(out_data), 0);
        @(negedge fclk);
        reset_n = 1;

        // Full-rate streaming: one packet per sclk period, output idle after each mid edge.
        sclk_cycles(1);
        in_vld = 1; out_rdy = 1;
        sclk_cycles(2);
        n0 = n_out;
        chk("stream_vld", 32'(out_vld), 1);
        chk("stream_rdy", 32'(in_rdy), 1);
        @(posedge fclk); #1;
        chk("alt_idle", 32'(out_vld), 0);
        sclk_cycles(10);
        chk("rate", 32'(n_out - n0), 10);

        // Source pause: drain, then resume at the next value.
        in_vld = 0;
        sclk_cycles(10);
        chk("drain_vld", 32'(out_vld), 0);
        chk("drain_rdy", 32'(in_rdy), 1);
        chk("drain_cnt", 32'(src - exp), 0);
        in_vld = 1;
        sclk_cycles(4);
        chk("resume_occ", 32'(src - exp), 1);

        // Output stall: buffer fills to depth, data held.
        out_rdy = 0;
        sclk_cycles(10);
        chk("full_rdy", 32'(in_rdy), 0);
        chk("full_vld", 32'(out_vld), 1);
        chk("full_occ", 32'(src - exp), 4);
        chk("full_head", 32'(out_data), 32'(16'(exp)));
        out_rdy = 1;
        sclk_cycles(10);
        chk("release_occ", 32'(src - exp), 1);

        // Drop both on a mid-sclk edge, refill while blocked.
        do begin @(posedge fclk); #1; end while (sclk);
        in_vld = 0; out_rdy = 0;
        sclk_cycles(2);
        chk("mid_empty", 32'(out_vld), 0);
        in_vld = 1;
        sclk_cycles(10);
        chk("mid_full_rdy", 32'(in_rdy), 0);
        chk("mid_full_occ", 32'(src - exp), 4);

        // Release so the first transfer lands on the mid-sclk edge.
        out_rdy = 1;
        e0 = exp;
        @(posedge fclk); #1;
        chk("mid_restart", 32'(exp - e0), 1);
        sclk_cycles(10);
        chk("mid_steady_occ", 32'(src - exp), 1);

        // Reset mid-stream, then restart from zero.
        #2 reset_n = 0;
        #1;
        chk("mrst_out_vld", 32'(out_vld), 0);
        chk("mrst_in_rdy", 32'(in_rdy), 0);
        chk("mrst_out_data", 32'(out_data), 0);
        sclk_cycles(2);
        reset_n = 1;
        sclk_cycles(10);
        chk("post_rst_src", 32'(src), 10);
        chk("post_rst_exp", 32'(exp), 9);
        in_vld = 0;
        sclk_cycles(3);
        chk("final_vld", 32'(out_vld), 0);
        chk("final_cnt", 32'(src - exp), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spio_link_speed_doubler.md
Name: spio_link_speed_doubler

Overview:
- Transfers a valid/ready packet stream from the slow clock domain (sclk_i) to a fast clock domain (fclk_i) running at exactly twice the sclk_i frequency, with rising edges aligned (synchronous, zero-skew, no CDC synchronisers).
- Lets a downstream link run at double rate while upstream logic stays on sclk_i.
- Lossless and order-preserving; must sustain one packet per sclk_i cycle.

Parameters:
- PKT_BITS, 16, packet width in bits.
- ADDR_BITS, 2, log2 of the internal buffer depth (default depth 4, minimum 1).

Ports:
- sclk_i  in  1  slow clock; input-side logic on its rising edge.
- reset_i  in  1  asynchronous, active-low reset; clears both domains.
- fclk_i  in  1  fast clock, 2x sclk_i, rising edges aligned with sclk_i rising edges.
- in_data_i  in  PKT_BITS  input packet (sclk_i domain).
- in_vld_i  in  1  input valid.
- in_rdy_o  out  1  input ready.
- out_data_o  out  PKT_BITS  output packet (fclk_i domain).
- out_vld_o  out  1  output valid.
- out_rdy_i  in  1  output ready.

Behaviour:
- Core is a circular buffer of 2^ADDR_BITS entries.
- Write pointer: ADDR_BITS+1 bits, sclk_i domain. Read pointer: ADDR_BITS+1 bits, fclk_i domain.
- Occupancy is wptr minus rptr, modulo 2^(ADDR_BITS+1). Full when the occupancy equals the depth. Empty when the occupancy is 0.
- Reset (reset_i low, asynchronous): both pointers are 0; in_rdy_o=0 while reset is asserted; out_vld_o=0; out_data_o=0.
- Input handshake: a transfer occurs at a sclk_i rising edge when in_vld_i and in_rdy_o are both high. The packet is written at wptr and wptr increments.
- in_rdy_o = not full, evaluated from the current pointers. A read on the coincident fclk_i edge is not credited until after that edge, which is conservative and safe.
- in_rdy_o must not depend combinationally on in_vld_i.
- Output handshake: out_vld_o = not empty. out_data_o = the entry at rptr.
- A transfer occurs at a fclk_i rising edge when out_vld_o and out_rdy_i are both high; rptr then increments.
- out_data_o is held stable while out_vld_o=1 and out_rdy_i=0.
- Latency: a packet written at sclk_i edge T drives out_vld_o immediately after T. With out_rdy_i=1 it is consumed at the next fclk_i edge (T + one fclk period).
- Throughput: 1 packet per sclk_i cycle in. Output idles on alternate fclk_i cycles at full input rate. No bubbles are inserted while in_vld_i stays high and out_rdy_i is high.
- Pointer wrap-around is natural binary wrap. Simultaneous write and read are both honoured.
- When full and out_rdy_i=0, in_rdy_o=0 and in_data_i is ignored. No packet is ever dropped, duplicated or reordered.
- in_vld_i and out_rdy_i may change on any fclk_i edge, including the mid-sclk edge; behaviour stays correct.
- Reset mid-operation: buffer contents are discarded. Streaming resumes cleanly after reset_i returns high.

Optional Feature:
- SPIO_LSD_OUTPUT_REG_EN defined: out_data_o and out_vld_o come from a registered fclk_i-domain output stage with a 2-entry skid buffer.
  - Adds exactly one fclk_i cycle of latency.
  - Keeps full throughput and keeps out_rdy_i off any combinational path.
  - Resets to out_vld_o=0 and out_data_o=0.
- Not defined: outputs are driven combinationally from the buffer as described above.

Test Plan:
- Reset, then in_vld_i=1 and out_rdy_i=1 for 200 ns, with the source sending 0,1,2,...: out_data_o delivers 0,1,2,... consecutively at one packet per 20 ns, with no gaps or duplicates.
- Drop in_vld_i for 200 ns, then restore it: out_vld_o falls once the buffer drains; the sequence resumes exactly at the next value.
- out_rdy_i=0 for 200 ns with in_vld_i=1: in_rdy_o falls after 4 packets are buffered and out_data_o holds steady. On release the held value plus the 3 buffered values emerge, then the sequence continues with no loss.
- Deassert in_vld_i and out_rdy_i together on a mid-sclk fclk_i edge, then reassert in_vld_i while the output stays blocked: the buffer fills to 4 and in_rdy_o=0 with no overflow.
- Release out_rdy_i on a mid-sclk fclk_i edge: transfer restarts on that fclk_i edge and the sequence stays continuous.
- Assert reset_i low mid-stream: out_vld_o=0 and in_rdy_o=0 immediately. After release, the sequence restarts from the source's post-reset value.
